// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan of a 4-digit common-anode seven-segment display
//   Ports: clk, rst (sync, active-high); value/value_valid/value_ready handshake into a
//   pending slot adopted at frame end; dp_in, digit_en live per-digit masks;
//   an (active-low anodes), seg {g..a} active-low, dp active-low, all registered.
//   Define SSD_LZ_BLANK_EN to darken leading-zero digits (digit 0 always shown).
module ssd_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int MAXC = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LOAD = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BL_LOAD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);

    typedef enum logic {ON, BLANK} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    logic [15:0]   shadow, pending;
    logic          pend_full, adv, frame_end, lit, lz_ok;
    logic [3:0]    nib;

    function automatic logic [6:0] dec(input logic [3:0] n);
        unique case (n)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            4'hF: dec = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - CW'(1);
        idx_nx   = idx;
        adv      = 1'b0;
        if (cnt == '0) begin
            if (state == ON && BLANK_CYCLES > 0) begin
                state_nx = BLANK;
                cnt_nx   = BL_LOAD;
            end else begin
                state_nx = ON;
                cnt_nx   = ON_LOAD;
                idx_nx   = idx + 2'd1;
                adv      = 1'b1;
            end
        end
    end

    assign frame_end   = adv && idx == 2'd3;
    assign value_ready = !pend_full;
    assign nib         = shadow[{idx, 2'b00} +: 4];
`ifdef SSD_LZ_BLANK_EN
    // a digit is lit only if it or some higher nibble is nonzero
    assign lz_ok = idx == 2'd0 || (shadow >> {idx, 2'b00}) != 16'd0;
`else
    assign lz_ok = 1'b1;
`endif
    assign lit = state == ON && digit_en[idx] && lz_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ON;
            cnt       <= ON_LOAD;
            idx       <= 2'd0;
            shadow    <= 16'd0;
            pending   <= 16'd0;
            pend_full <= 1'b0;
            an        <= 4'hF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            an    <= lit ? ~(4'b0001 << idx) : 4'hF;
            seg   <= lit ? dec(nib) : 7'h7F;
            dp    <= lit ? ~dp_in[idx] : 1'b1;
            // accept only into an empty slot, so it never collides with adoption
            if (value_valid && !pend_full) begin
                pending   <= value;
                pend_full <= 1'b1;
            end else if (frame_end && pend_full) begin
                shadow    <= pending;
                pend_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl against a time-arithmetic display model
module tb_ssd_scan_ctrl;
    localparam int R = 4;
    localparam int B = 1;
    localparam int P = R + B;
    localparam int F = 4 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'd0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic [3:0]  dp_in = 4'd0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    ssd_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
        .value_ready(value_ready), .dp_in(dp_in), .digit_en(digit_en),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } obs_t;

    obs_t        exp_q[$];
    logic [15:0] offers[$];
    logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          checks = 0;
    int          passed = 0;
    int          tau = 0;
    logic [15:0] m_shadow = 16'd0;
    logic [15:0] m_pend = 16'd0;
    logic        m_full = 1'b0;

    // display at scan time tau: digit d = (tau/P) mod 4, lit for the first R cycles of a slot
    function automatic obs_t model_now();
        obs_t e;
        int   d;
        logic lit;
        d   = (tau / P) % 4;
        lit = (tau % P) < R && digit_en[d];
`ifdef SSD_LZ_BLANK_EN
        if (d != 0 && (m_shadow >> (4 * d)) == 16'd0) lit = 1'b0;
`endif
        e.an  = lit ? ~(4'b0001 << d) : 4'hF;
        e.seg = lit ? tbl[m_shadow[4*d +: 4]] : 7'h7F;
        e.dp  = lit ? ~dp_in[d] : 1'b1;
        e.rdy = 1'b1;
        return e;
    endfunction

    task automatic step(input logic r, input int n, input logic rnd);
        obs_t e;
        logic rr;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rr = r;
            if (rnd) begin
                digit_en = 4'($urandom);
                dp_in    = 4'($urandom);
                if (offers.size() == 0 && $urandom_range(0, 7) == 0) offers.push_back(16'($urandom));
                rr = $urandom_range(0, 299) == 0;
            end
            rst         = rr;
            value_valid = offers.size() > 0;
            if (value_valid) value = offers[0];
            if (rr) begin
                e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, rdy: 1'b1};
                tau = 0; m_shadow = 16'd0; m_pend = 16'd0; m_full = 1'b0;
            end else begin
                e = model_now();
                if (value_valid && !m_full) begin
                    m_pend = value; m_full = 1'b1;
                    void'(offers.pop_front());
                end else if (tau % F == F - 1 && m_full) begin
                    m_shadow = m_pend; m_full = 1'b0;
                end
                tau++;
                e.rdy = !m_full;
            end
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        obs_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, value_ready} === e) passed++;
            else $display("FAIL pins t=%0t: got an=%b seg=%h dp=%b rdy=%b expected an=%b seg=%h dp=%b rdy=%b",
                          $time, an, seg, dp, value_ready, e.an, e.seg, e.dp, e.rdy);
        end
    end

    initial begin
        int k;
        step(1, 3, 0);
        step(0, 10, 0);
        offers.push_back(16'h1234);
        step(0, 5, 0);
        offers.push_back(16'hABCD);
        step(0, 70, 0);
        digit_en = 4'b0101; dp_in = 4'b0001;
        offers.push_back(16'h8888);
        step(0, 50, 0);
        digit_en = 4'hF; dp_in = 4'h0;
        offers.push_back(16'h0042);
        step(0, 50, 0);
        offers.push_back(16'h5555);
        offers.push_back(16'h7777);
        k = 0;
        while (k < 200 && !(m_full && (tau / P) % 4 == 2)) begin
            step(0, 1, 0);
            k++;
        end
        if (k == 200) begin
            checks++;
            $display("FAIL midscan_setup: got no pending slot in digit 2 within 200 cycles, expected one");
        end
        offers.delete();
        step(1, 1, 0);
        step(0, 30, 0);
        step(0, 1500, 1);
        step(0, 5, 0);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Time-multiplexing scan controller for the 4-digit common-anode seven-segment display. It converts a 16-bit hex value into per-digit anode and segment drive, with a programmable on-time per digit and an anti-ghosting blank gap between digits. New values arrive through a valid/ready handshake into a pending slot and are adopted only at frame boundaries, so a displayed frame never mixes two values. It sits between the switch/value source and the board display pins.

## Interface
- REFRESH_DIV, 50000: clk cycles each digit is lit per visit; legal range ≥1.
- BLANK_CYCLES, 16: clk cycles with all anodes off after each digit; 0 means no gap.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- value  in  16  hex value; nibble n drives digit n, and digit 0 is the rightmost.
- value_valid  in  1  offer of `value`.
- value_ready  out  1  pending slot empty; the value is accepted when valid && ready.
- dp_in  in  4  decimal point request per digit, active-high.
- digit_en  in  4  per-digit enable; a disabled digit stays dark in its slot.
- an  out  4  anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Registers:
  - shadow[15:0]: the value being displayed.
  - pending[15:0] with pend_full.
  - digit index idx[1:0].
  - state ∈ {ON, BLANK}.
  - countdown counter, width $clog2(max(REFRESH_DIV, BLANK_CYCLES, 1)).
- State machine:
  - ON: the counter runs REFRESH_DIV cycles. Then go to BLANK if BLANK_CYCLES > 0. Otherwise advance idx and stay in ON.
  - BLANK: the counter runs BLANK_CYCLES cycles, then advance idx and go to ON.
  - idx advances 0→1→2→3→0.
- Frame end: the cycle in which idx wraps 3→0. If pend_full is set at frame end: shadow ← pending and pend_full ← 0.
- value_ready = !pend_full.
  - On valid && ready, pending ← value and pend_full ← 1.
  - If acceptance and frame end occur in the same cycle, the slot was empty: the new value goes to pending and is shown from the next frame end.
  - A second offer while pend_full is set waits; the source holds it.
- Segment decode for the active nibble, hex 0–F, 7'h{g..a} active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Output drive:
  - In ON with digit_en[idx]=1: an = ~(1<<idx), seg = decode(shadow[4*idx+:4]), dp = ~dp_in[idx].
  - In BLANK, or when the digit is disabled: an=4'hF, seg=7'h7F, dp=1.
- digit_en and dp_in are sampled live and are not frame-buffered. Disabling a digit never changes slot timing.

## Timing
- Outputs an, seg, and dp are registered: one cycle of latency from state/idx to pins.
- Reset values:
  - an=4'hF, seg=7'h7F, dp=1.
  - value_ready=1, shadow=0, pend_full=0, idx=0, state=ON, counter loaded.
- First clock edge with rst=0: an=4'b1110, seg=7'h40 (shadow 0).
- Frame period = 4·(REFRESH_DIV+BLANK_CYCLES) cycles.
- Worst-case latency from accept to display = 2 frames.
- rst asserted mid-scan:
  - Next edge forces reset values.
  - A pending value is discarded and shadow clears to 0.
  - Scan restarts at digit 0.
- value_ready has zero-cycle dependency on value_valid only through registered pend_full; no combinational path.

## Configuration
- SSD_LZ_BLANK_EN defined: leading-zero blanking.
  - Digits above the most significant nonzero nibble of shadow are dark (an bit high, seg=7'h7F, dp=1) in their slots.
  - Digit 0 is always shown, so shadow=0 displays "0".
  - Digit timing is unchanged.
- SSD_LZ_BLANK_EN undefined: all enabled digits show their nibble, including leading zeros.

## Test plan
- Reset: hold rst 3 cycles → an=F, seg=7F, dp=1, value_ready=1. After release, first edge gives an=1110, seg=40.
- Scan with REFRESH_DIV=4, BLANK_CYCLES=1, value=0x1234 accepted, after one frame:
  - an cycles 1110/F/1101/F/1011/F/0111/F.
  - Lit phases are 4 cycles, gaps 1 cycle.
  - seg=19, 30, 24, 79 (digits 0–3).
- Tear-free update: accept 0x1234, then offer 0xABCD mid-frame → ready=0 until frame end. Digits show 1234 for the whole frame, then ABCD from the next frame end; ready rises after the 1234 adoption.
- Masks: digit_en=4'b0101, dp_in=4'b0001, value=0x8888 → digits 1 and 3 dark in their slots with slot timing unchanged; digit 0 shows seg=00, dp=0.
- Reset mid-scan during digit 2 with pend_full=1 → next edge gives reset values, pending is dropped, restart shows 0 on digit 0.
- With SSD_LZ_BLANK_EN, value=0x0042 → digits 3 and 2 are dark, digit 1 seg=19, digit 0 seg=24. Without the macro, digits 3 and 2 show seg=40.
